multicycle_alu: RTL
===================

# multicycle_alu

Parametrised, registered ALU with iterative unsigned multiply, divide and remainder, driven by a Start/Busy/Done handshake. It extends the single-cycle RV32 ALU operation set with XOR and SLTU and adds shift-add and restoring-division engines, so a multicycle datapath can stall on long operations. It sits in the execute stage behind the SrcA/SrcB muxes. Results and the Zero flag are registered and held until the next completion.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 4)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- Start  input  1  request; sampled only while the block is not busy
- ALUControl  input  4  operation code, sampled with Start
- SrcA  input  WIDTH  operand A, sampled with Start
- SrcB  input  WIDTH  operand B, sampled with Start
- Busy  output  1  iterative operation in progress
- Done  output  1  one-cycle pulse; ALUResult and Zero are updated in the same cycle
- ALUResult  output  WIDTH  registered result
- Zero  output  1  registered flag, equal to (ALUResult == 0)

## Operation
- Opcodes:
  - 0000 ADD and 0001 SUB: modulo 2^WIDTH.
  - 0010 AND, 0011 OR, 0110 XOR.
  - 0100 PASS: result = SrcB.
  - 0101 SLT: signed compare; result = {0…, A<B}.
  - 0111 SLTU: unsigned compare; result = {0…, A<B}.
  - 1000 MUL: low WIDTH bits of the unsigned product.
  - 1001 DIVU: unsigned quotient.
  - 1010 REMU: unsigned remainder.
  - All other codes: result 0, single-cycle.
- States:
  - IDLE: accepts Start.
  - MUL: shift-add, one multiplier bit per cycle.
  - DIV: restoring division, one quotient bit per cycle.
- IDLE + Start + single-cycle op: compute from the sampled operands, write ALUResult/Zero, pulse Done, stay in IDLE.
- IDLE + Start + MUL/DIVU/REMU: latch operands and the op, clear the iteration counter, go to MUL or DIV, assert Busy.
- MUL/DIV iteration: run one step per cycle.
  - When the counter reaches WIDTH-1, write the final ALUResult/Zero, pulse Done, deassert Busy and return to IDLE.
- Divide by zero (SrcB = 0):
  - DIVU result is all ones; REMU result is SrcA.
  - Latency is the same as for a nonzero divisor (fixed latency).
- Start while Busy is ignored. Operands and opcode changing mid-operation have no effect, because they are latched.
- Back-to-back: Start asserted in the same cycle Done is high is accepted (the block is in IDLE).
- Internal accumulator/remainder registers are WIDTH+1 bits; only WIDTH bits reach ALUResult.

## Timing
- Reset (rst_n low, asynchronous):
  - State becomes IDLE; the counter is cleared.
  - Busy = 0, Done = 0, ALUResult = 0, Zero = 1.
  - Takes effect immediately, including mid-operation; any partial result is discarded and Done does not pulse.
- Single-cycle ops: Start sampled at edge N; Done = 1 and result valid after edge N (latency 1).
- Iterative ops:
  - Start sampled at edge N; Busy = 1 after edge N.
  - Done = 1 and Busy = 0 after edge N+WIDTH (latency WIDTH+1 cycles, including the accept cycle).
- Done is high for exactly one cycle. ALUResult/Zero hold their values until the next Done.
- Busy and Done are never high together.

## Test plan
- ADD 0x00000011 + 0x00000022 → ALUResult 0x00000033, Zero 0, Done one cycle after Start; SUB 0x5−0x5 → 0, Zero 1.
- SLT 0x00000001 vs 0xF0F00002 → 0; SLTU with the same operands → 1; XOR 0x00FF ^ 0x0F0F → 0x0FF0.
- MUL 0x00010003 × 0x00000005 → 0x0005000F; Busy for 32 cycles; Done exactly 32 cycles after the accept cycle (latency 33); Start pulses while Busy are ignored.
- DIVU 100/7 → 14 and REMU 100/7 → 2; DIVU x/0 → 0xFFFFFFFF and REMU 0x1234/0 → 0x1234, both with full latency.
- Back-to-back: MUL then ADD with Start re-asserted on the Done cycle → ADD Done follows one cycle later.
- rst_n pulsed low 10 cycles into a DIVU → Busy 0, ALUResult 0, Zero 1 immediately, and no Done pulse afterwards.

Source files
------------

// File: rtl/multicycle_alu.sv
// Registered RV32-style ALU with iterative unsigned MUL/DIVU/REMU.
// Start/Busy/Done handshake; result and Zero held until the next Done.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_PASS = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic             is_rem_q;
    // a_q: multiplicand (shifts left) or dividend/quotient (shifts left)
    logic [WIDTH-1:0] a_q;
    // b_q: multiplier (shifts right) or divisor (held)
    logic [WIDTH-1:0] b_q;
    // acc_q: product accumulator or partial remainder
    logic [WIDTH:0]   acc_q;

    logic [WIDTH-1:0] alu_d;
    logic [WIDTH:0]   prod_d;
    logic [WIDTH:0]   rsh_d;
    logic             ge_d;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;
    logic             last_d;

    // Single-cycle operation result from the live operands
    always_comb begin
        alu_d = '0;
        case (ALUControl)
            OP_ADD:  alu_d = SrcA + SrcB;
            OP_SUB:  alu_d = SrcA - SrcB;
            OP_AND:  alu_d = SrcA & SrcB;
            OP_OR:   alu_d = SrcA | SrcB;
            OP_XOR:  alu_d = SrcA ^ SrcB;
            OP_PASS: alu_d = SrcB;
            OP_SLT:  alu_d = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            OP_SLTU: alu_d = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
            default: alu_d = '0;
        endcase
    end

    // One shift-add step and one restoring-division step
    always_comb begin
        prod_d = acc_q + (b_q[0] ? {1'b0, a_q} : '0);
        rsh_d  = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
        ge_d   = rsh_d >= {1'b0, b_q};
        rem_d  = ge_d ? (rsh_d - {1'b0, b_q}) : rsh_d;
        quo_d  = {a_q[WIDTH-2:0], ge_d};
        last_d = cnt_q == CW'(WIDTH - 1);
    end

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= '0;
            zero_q   <= 1'b1;
            is_rem_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        if (ALUControl == OP_MUL ||
                            ALUControl == OP_DIVU ||
                            ALUControl == OP_REMU) begin
                            a_q      <= SrcA;
                            b_q      <= SrcB;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            is_rem_q <= ALUControl == OP_REMU;
                            busy_q   <= 1'b1;
                            state_q  <= (ALUControl == OP_MUL) ? S_MUL : S_DIV;
                        end else begin
                            res_q  <= alu_d;
                            zero_q <= alu_d == '0;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= prod_d;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_d) begin
                        res_q   <= prod_d[WIDTH-1:0];
                        zero_q  <= prod_d[WIDTH-1:0] == '0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_DIV: begin
                    acc_q <= rem_d;
                    a_q   <= quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_d) begin
                        res_q   <= is_rem_q ? rem_d[WIDTH-1:0] : quo_d;
                        zero_q  <= (is_rem_q ? rem_d[WIDTH-1:0] : quo_d) == '0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign ALUResult = res_q;
    assign Zero      = zero_q;

endmodule
